rsp_prep_rd_sched: RTL and testbench



---
 rtl/rsp_prep_pkg.sv | 31 +++
 rtl/rsp_prep_rd_sched_delay.sv | 25 ++
 rtl/rsp_prep_rd_sched.sv | 160 ++++++++++++++++
 tb/tb_rsp_prep_rd_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_prep_pkg.sv
// Shared types and helpers for the prep-stage RAM read scheduler.
package rsp_prep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int MAX_REQ    = 32;
   localparam int N_REQ_DFLT = 2;

   function automatic int id_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ID_W = id_w(N_REQ_DFLT);

   // First requester at or after ptr; scanning downward lets the nearest one win.
   function automatic int rr_pick(logic [MAX_REQ-1:0] req, int ptr, int n);
      int pick;
      int idx;
      pick = 0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         idx = (ptr + k) % n;
         if (k < n && req[5'(idx)]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/rsp_prep_rd_sched_delay.sv
// Fixed-depth shift-register delay with synchronous clear.
module rsp_delay_line #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/rsp_prep_rd_sched.sv
// Shares one RAM read port between N_REQ prep requesters; round-robin by default,
// fixed priority (lowest index) when RSP_RD_SCHED_FIXED_PRIO_EN is defined.
//   state | meaning
//   IDLE  | waiting for a request; grant issued here
//   BURST | rd_en high, one beat per cycle
//   GAP   | forced idle after a burst, requests ignored
module rsp_prep_rd_sched
   import rsp_prep_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int ADDR_W         = 18,
   parameter int NUM_W          = 16,
   parameter int ADD_ADDR       = 16,
   parameter int READ_RAM_WIDTH = 128,
   parameter int RD_LATENCY     = 5,
   parameter int RD_GAP         = 50
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ*ADDR_W-1:0]   i_start_addr,
   input  logic [N_REQ*ADDR_W-1:0]   i_end_addr,
   input  logic [N_REQ*NUM_W-1:0]    i_num,
   output logic [N_REQ-1:0]          o_ack,
   output logic                      o_busy,
   output logic [ADDR_W-1:0]         o_m0_rd_addr,
   output logic                      o_m0_rd_en,
   input  logic [READ_RAM_WIDTH-1:0] i_m0_rd_data,
   output logic [READ_RAM_WIDTH-1:0] o_data,
   output logic                      o_data_valid,
   output logic                      o_data_last,
   output logic [id_w(N_REQ)-1:0]    o_data_id
);

   localparam int IDW   = id_w(N_REQ);
   localparam int GAP_W = (RD_GAP > 1) ? $clog2(RD_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((RD_GAP > 0) ? RD_GAP - 1 : 0);

   state_t             state, state_nx;
   logic [N_REQ-1:0]   req_eff;
   logic               take;
   logic               last_beat;
   int                 gi;
   logic [IDW-1:0]     grant_idx;
   logic [ADDR_W-1:0]  start_sel, end_sel;
   logic [NUM_W-1:0]   num_sel;
   logic [ADDR_W-1:0]  start_q, end_q;
   logic [NUM_W-1:0]   num_q, beat;
   logic [IDW-1:0]     owner;
   logic [GAP_W-1:0]   gap_cnt;

`ifndef RSP_RD_SCHED_FIXED_PRIO_EN
   logic [IDW-1:0]     rr_ptr;

   always_ff @(posedge clk) begin
      if (rst) rr_ptr <= '0;
      else if (take) rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (take && num_sel != '0) state_nx = BURST;
         BURST:   if (last_beat) state_nx = (RD_GAP == 0) ? IDLE : GAP;
         GAP:     if (gap_cnt == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A requester is masked while its own ack is on the wire, since it can only drop req afterwards.
   always_comb begin
      req_eff   = (state == IDLE) ? (i_req & ~o_ack) : '0;
      take      = |req_eff;
      last_beat = (state == BURST) && (beat == num_q - NUM_W'(1));
      o_busy    = (state != IDLE);
`ifdef RSP_RD_SCHED_FIXED_PRIO_EN
      gi        = rr_pick(MAX_REQ'(req_eff), 0, N_REQ);
`else
      gi        = rr_pick(MAX_REQ'(req_eff), int'(rr_ptr), N_REQ);
`endif
      grant_idx = IDW'(gi);
      start_sel = i_start_addr[ADDR_W-1:0];
      end_sel   = i_end_addr[ADDR_W-1:0];
      num_sel   = i_num[NUM_W-1:0];
      for (int r = 1; r < N_REQ; r++) begin
         if (grant_idx == IDW'(r)) begin
            start_sel = i_start_addr[r*ADDR_W +: ADDR_W];
            end_sel   = i_end_addr[r*ADDR_W +: ADDR_W];
            num_sel   = i_num[r*NUM_W +: NUM_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_ack        <= '0;
         o_m0_rd_en   <= 1'b0;
         o_m0_rd_addr <= '0;
         o_data       <= '0;
         start_q      <= '0;
         end_q        <= '0;
         num_q        <= '0;
         beat         <= '0;
         owner        <= '0;
         gap_cnt      <= '0;
      end else begin
         o_ack  <= '0;
         o_data <= i_m0_rd_data;
         if (take) begin
            o_ack      <= N_REQ'(1) << grant_idx;
            start_q    <= start_sel;
            end_q      <= end_sel;
            num_q      <= num_sel;
            owner      <= grant_idx;
            beat       <= '0;
            o_m0_rd_en <= (num_sel != '0);
            if (num_sel != '0) o_m0_rd_addr <= start_sel;
         end else if (state == BURST) begin
            if (last_beat) begin
               o_m0_rd_en <= 1'b0;
               gap_cnt    <= GAP_LOAD;
            end else begin
               beat         <= beat + NUM_W'(1);
               o_m0_rd_addr <= (o_m0_rd_addr == end_q) ? start_q
                                                       : o_m0_rd_addr + ADDR_W'(ADD_ADDR);
            end
         end else if (state == GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

   rsp_delay_line #(.W(1), .DEPTH(RD_LATENCY)) u_dly_valid (
      .clk (clk),
      .rst (rst),
      .d   (o_m0_rd_en),
      .q   (o_data_valid)
   );

   rsp_delay_line #(.W(1), .DEPTH(RD_LATENCY)) u_dly_last (
      .clk (clk),
      .rst (rst),
      .d   (o_m0_rd_en & last_beat),
      .q   (o_data_last)
   );

   rsp_delay_line #(.W(IDW), .DEPTH(RD_LATENCY)) u_dly_id (
      .clk (clk),
      .rst (rst),
      .d   (owner),
      .q   (o_data_id)
   );

endmodule

// File: tb/tb_rsp_prep_rd_sched.sv
// Directed scoreboard bench for rsp_prep_rd_sched (honours RSP_RD_SCHED_FIXED_PRIO_EN).
module tb_rsp_prep_rd_sched;

   localparam int N_REQ      = 2;
   localparam int ADDR_W     = 18;
   localparam int NUM_W      = 16;
   localparam int ADD_ADDR   = 16;
   localparam int DW         = 128;
   localparam int RD_LATENCY = 5;
   localparam int RD_GAP     = 50;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          last;
      logic          id;
   } beat_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [N_REQ-1:0]        req = '0;
   logic [N_REQ*ADDR_W-1:0] start_addr = '0;
   logic [N_REQ*ADDR_W-1:0] end_addr = '0;
   logic [N_REQ*NUM_W-1:0]  num = '0;
   logic [N_REQ-1:0]        ack;
   logic                    busy;
   logic [ADDR_W-1:0]       rd_addr;
   logic                    rd_en;
   logic [DW-1:0]           rd_data;
   logic [DW-1:0]           data;
   logic                    data_valid;
   logic                    data_last;
   logic [0:0]              data_id;

   rsp_prep_rd_sched #(
      .N_REQ(N_REQ), .ADDR_W(ADDR_W), .NUM_W(NUM_W), .ADD_ADDR(ADD_ADDR),
      .READ_RAM_WIDTH(DW), .RD_LATENCY(RD_LATENCY), .RD_GAP(RD_GAP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req        (req),
      .i_start_addr (start_addr),
      .i_end_addr   (end_addr),
      .i_num        (num),
      .o_ack        (ack),
      .o_busy       (busy),
      .o_m0_rd_addr (rd_addr),
      .o_m0_rd_en   (rd_en),
      .i_m0_rd_data (rd_data),
      .o_data       (data),
      .o_data_valid (data_valid),
      .o_data_last  (data_last),
      .o_data_id    (data_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] ram_word(logic [ADDR_W-1:0] a);
      return {4{{14'h2a5, a} ^ 32'h5A5A_0000}};
   endfunction

   // RAM model: data for an address appears RD_LATENCY-1 cycles after it was driven.
   logic [ADDR_W-1:0] ahist [RD_LATENCY-1] = '{default: '0};
   always @(posedge clk) begin
      ahist[0] <= rd_addr;
      for (int i = 1; i < RD_LATENCY - 1; i++) ahist[i] <= ahist[i-1];
   end
   assign rd_data = ram_word(ahist[RD_LATENCY-2]);

   int total = 0;
   int bad = 0;

   task automatic check(string tag, logic [159:0] obs, logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [ADDR_W-1:0] exp_addr [$];
   beat_t             exp_q [$];
   int                vcyc [$];
   int                fall_cyc = 0;
   logic              prev_en = 1'b0;
   int                rr_m = 0;

   always @(negedge clk) begin
      beat_t b;
      if (rd_en === 1'b1) begin
         if (exp_addr.size() == 0) check("rd_en_unexpected", exp_addr.size(), 1);
         else check("rd_addr", rd_addr, exp_addr.pop_front());
         vcyc.push_back(cyc + RD_LATENCY);
      end
      if (data_valid === 1'b1) begin
         if (exp_q.size() == 0) check("valid_unexpected", exp_q.size(), 1);
         else begin
            b = exp_q.pop_front();
            check("rd_beat", {data, data_last, data_id}, b);
            check("valid_latency", cyc, (vcyc.size() != 0) ? vcyc.pop_front() : -1);
         end
      end
      if (prev_en === 1'b1 && rd_en === 1'b0) fall_cyc = cyc;
      prev_en = rd_en;
   end

   function automatic int pick(logic [1:0] rq);
`ifdef RSP_RD_SCHED_FIXED_PRIO_EN
      return rq[0] ? 0 : 1;
`else
      if (rq[rr_m[0]]) return rr_m;
      return 1 - rr_m;
`endif
   endfunction

   task automatic set_job(int r, logic [ADDR_W-1:0] s, logic [ADDR_W-1:0] e, logic [NUM_W-1:0] n);
      logic [ADDR_W-1:0] a;
      if (r == 0) begin
         start_addr[ADDR_W-1:0] = s;
         end_addr[ADDR_W-1:0]   = e;
         num[NUM_W-1:0]         = n;
      end else begin
         start_addr[2*ADDR_W-1:ADDR_W] = s;
         end_addr[2*ADDR_W-1:ADDR_W]   = e;
         num[2*NUM_W-1:NUM_W]          = n;
      end
      a = s;
      for (int k = 0; k < int'(n); k++) begin
         exp_addr.push_back(a);
         exp_q.push_back('{d: ram_word(a), last: (k == int'(n) - 1), id: r[0]});
         a = (a == e) ? s : a + ADDR_W'(ADD_ADDR);
      end
   endtask

   task automatic wait_ack(int r, int lim, output int when);
      bit got;
      got  = 1'b0;
      when = -1;
      for (int k = 0; k < lim && !got; k++) begin
         @(negedge clk);
         if (ack[r[0]] === 1'b1) begin
            got  = 1'b1;
            when = cyc;
            check("ack_onehot", ack, 2'b01 << r);
            req[r[0]] = 1'b0;
            rr_m = (r + 1) % 2;
         end
      end
      check($sformatf("ack%0d_seen", r), got, 1);
   endtask

   task automatic drain(int lim);
      bit done;
      done = 1'b0;
      for (int k = 0; k < lim && !done; k++) begin
         @(negedge clk);
         if (busy === 1'b0 && data_valid === 1'b0 && ack === '0 &&
             exp_q.size() == 0 && exp_addr.size() == 0) done = 1'b1;
      end
      check("drain", done, 1);
   endtask

   task automatic pair_test(string tag);
      int w, o, t, when;
      w = pick(2'b11);
      o = 1 - w;
      t = cyc;
      set_job(w, (w == 0) ? 18'h080 : 18'h180, (w == 0) ? 18'h090 : 18'h190, 16'd2);
      set_job(o, (o == 0) ? 18'h080 : 18'h180, (o == 0) ? 18'h090 : 18'h190, 16'd2);
      req = 2'b11;
      wait_ack(w, 10, when);
      check({tag, "_first_lat"}, when - t, 1);
      wait_ack(o, 200, when);
      check({tag, "_gap_ack"}, when - fall_cyc, RD_GAP + 1);
      drain(200);
   endtask

   initial begin
      int t, when, nv;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", data_valid, 0);
      check("rst_last", data_last, 0);
      check("rst_id", data_id, 0);
      check("rst_data", data, 0);
      rst = 1'b0;
      @(negedge clk);

      // basic burst, requester 0
      t = cyc;
      set_job(0, 18'h0, 18'd48, 16'd4);
      req[0] = 1'b1;
      wait_ack(0, 10, when);
      check("t1_ack_lat", when - t, 1);
      check("t1_rd_en_with_ack", rd_en, 1);
      check("t1_busy", busy, 1);
      drain(200);

      // ring wrap, requester 1
      t = cyc;
      set_job(1, 18'h100, 18'h120, 16'd5);
      req[1] = 1'b1;
      wait_ack(1, 10, when);
      check("t2_ack_lat", when - t, 1);
      drain(200);

      pair_test("pair_a");

      // zero-length job, then an immediate follow-up request
      t = cyc;
      set_job(0, 18'h040, 18'h040, 16'd0);
      req[0] = 1'b1;
      wait_ack(0, 10, when);
      check("t4_ack_lat", when - t, 1);
      check("t4_zero_rd_en", rd_en, 0);
      check("t4_zero_busy", busy, 0);
      t = cyc;
      set_job(1, 18'h040, 18'h060, 16'd3);
      req[1] = 1'b1;
      wait_ack(1, 10, when);
      check("t4_next_ack_lat", when - t, 1);
      drain(200);

      // request raised during GAP; address wraps through 2^ADDR_W
      t = cyc;
      set_job(1, 18'h1F0, 18'h1F0, 16'd1);
      req[1] = 1'b1;
      wait_ack(1, 10, when);
      check("t5_ack_lat", when - t, 1);
      repeat (4) @(negedge clk);
      check("t5_busy_in_gap", busy, 1);
      set_job(0, 18'h3FFE0, 18'h3FFFF, 16'd3);
      req[0] = 1'b1;
      wait_ack(0, 100, when);
      check("t5_gap_req_ack", when - fall_cyc, RD_GAP + 1);
      drain(200);

      pair_test("pair_b");

      // reset on the third beat of an 8-beat burst
      t = cyc;
      set_job(0, 18'h200, 18'h270, 16'd8);
      req[0] = 1'b1;
      wait_ack(0, 10, when);
      check("t7_ack_lat", when - t, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t7_rst_rd_en", rd_en, 0);
      check("t7_rst_valid", data_valid, 0);
      check("t7_rst_last", data_last, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_ack", ack, 0);
      exp_q.delete();
      exp_addr.delete();
      vcyc.delete();
      rst = 1'b0;
      rr_m = 0;
      nv = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (data_valid === 1'b1 || rd_en === 1'b1) nv++;
      end
      check("t7_no_beats_after_rst", nv, 0);

      t = cyc;
      set_job(0, 18'h200, 18'h270, 16'd3);
      req[0] = 1'b1;
      wait_ack(0, 10, when);
      check("t8_ack_lat", when - t, 1);
      drain(200);

      check("final_addr_q_empty", exp_addr.size(), 0);
      check("final_beat_q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
